// File: rtl/mem_if_pkg.sv
// mem_if_pkg: encodings and defaults shared by the cache controller and the memory responder.
package mem_if_pkg;
  localparam logic READ = 1'b0;
  localparam logic WRITE = 1'b1;
  localparam int DEF_WORDS_PER_BLOCK = 4;
  localparam int DEF_LATENCY = 4;
  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: word storage with synchronous write and asynchronous read.
// Word i powers up holding the value i, and reset does not touch the contents.
module mem_array #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] words [2**AW];
  for (genvar i = 0; i < 2**AW; i++) begin : g_word
    logic [DW-1:0] word_q = DW'(i);
    always_ff @(posedge clk)
      if (we && waddr == AW'(i)) word_q <= wdata;
    assign words[i] = word_q;
  end
  assign rdata = words[raddr];
endmodule

// File: rtl/block_mem_responder.sv
// block_mem_responder: clocked main memory that serves block reads and writes
// after a fixed access latency, one word per cycle, ending with a mem_done pulse.
module block_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int LATENCY = DEF_LATENCY,
  localparam int BEAT_W = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              r_w_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic              wr_ready,
  output logic [BEAT_W-1:0] beat,
  output logic              busy,
  output logic              mem_done
);
  localparam int WORD_W = ADDR_W - 2;
  localparam int BLK_W = WORD_W - BEAT_W;
  localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              rw_q, rw_d;
  logic              xfer;
  logic [DATA_W-1:0] mem_rdata;
  logic              addr_unused;

  // Byte offset and word-in-block bits never select a block.
  assign addr_unused = ^addr[ADDR_W-BLK_W-1:0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      blk_q   <= '0;
      rw_q    <= READ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      blk_q   <= blk_d;
      rw_q    <= rw_d;
    end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    blk_d   = blk_q;
    rw_d    = rw_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = WAIT;
        blk_d   = addr[ADDR_W-1 -: BLK_W];
        rw_d    = r_w_type;
        cnt_d   = CNT_W'(LATENCY - 1);
      end
      WAIT: if (cnt_q == '0) begin
        state_d = XFER;
        beat_d  = '0;
      end else cnt_d = cnt_q - 1'b1;
      XFER: begin
        beat_d  = beat_q + 1'b1;
        state_d = beat_q == BEAT_W'(WORDS_PER_BLOCK - 1) ? DONE : XFER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    xfer      = state_q == XFER;
    busy      = state_q != IDLE;
    mem_done  = state_q == DONE;
    rd_valid  = xfer && rw_q == READ;
    wr_ready  = xfer && rw_q == WRITE;
    read_data = rd_valid ? mem_rdata : '0;
    beat      = beat_q;
  end

  mem_array #(.AW(WORD_W), .DW(DATA_W)) u_mem (
    .clk  (clk),
    .we   (wr_ready),
    .waddr({blk_q, beat_q}),
    .wdata(write_data),
    .raddr({blk_q, beat_q}),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder: directed block reads/writes checked every cycle against a
// transaction-level timing model, plus literal expectations for selected results.
module tb_block_mem_responder;
  import mem_if_pkg::*;
  localparam int LAT = 4;
  localparam int W = 4;

  logic        clk = 0, rst_n = 1, req = 0, r_w_type = 0;
  logic [9:0]  addr = '0;
  logic [31:0] write_data, read_data;
  logic        rd_valid, wr_ready, busy, mem_done;
  logic [1:0]  beat;
  logic [31:0] wbuf [W];

  logic        s_req = 0;
  logic [9:0]  s_addr = '0;
  logic [31:0] s_rd;
  logic        s_rv, s_wr, s_busy, s_done;
  logic [0:0]  s_beat;

  int vectors = 0, errors = 0;

  always #5 clk = ~clk;
  assign write_data = wbuf[beat];

  block_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .req(req), .r_w_type(r_w_type), .addr(addr),
    .write_data(write_data), .read_data(read_data), .rd_valid(rd_valid),
    .wr_ready(wr_ready), .beat(beat), .busy(busy), .mem_done(mem_done)
  );

  block_mem_responder #(.LATENCY(1), .WORDS_PER_BLOCK(2)) u_small (
    .clk(clk), .rst_n(rst_n), .req(s_req), .r_w_type(READ), .addr(s_addr),
    .write_data(32'h0), .read_data(s_rd), .rd_valid(s_rv),
    .wr_ready(s_wr), .beat(s_beat), .busy(s_busy), .mem_done(s_done)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a request sampled at edge t0 owns cycles t0+1 .. t0+LAT+W+1.
  int unsigned model_mem [256];
  int  cyc = 0, t0 = 0, m_blk = 0;
  bit  active = 0, m_rw = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int k;
    if (!rst_n) active = 0;
    else begin
      k = cyc - t0;
      if (active && m_rw && k > LAT && k <= LAT + W) model_mem[m_blk * W + k - LAT - 1] = write_data;
      if (active && k == LAT + W + 1) active = 0;
      else if (!active && req) begin
        active = 1;
        t0 = cyc;
        m_rw = r_w_type;
        m_blk = int'(addr) / (4 * W);
      end
      cyc++;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) if (chk_en) begin : cmp
    int k, b;
    bit on, x;
    k = cyc - t0;
    on = rst_n && active;
    x = on && k > LAT && k <= LAT + W;
    b = k - LAT - 1;
    check("busy", busy, on);
    check("rd_valid", rd_valid, x && !m_rw);
    check("wr_ready", wr_ready, x && m_rw);
    check("mem_done", mem_done, on && k == LAT + W + 1);
    check("read_data", read_data, (x && !m_rw) ? model_mem[m_blk * W + b] : 32'h0);
    if (x) check("beat", beat, b);
  end

  task automatic start(logic rw, logic [9:0] a);
    @(posedge clk); #1;
    req = 1;
    r_w_type = rw;
    addr = a;
  endtask

  task automatic finish_txn(bit keep, bit tog, logic [9:0] na, output int lat,
                            output logic [31:0] rd [W], output int first_beat);
    int n = 0;
    first_beat = -1;
    for (int i = 0; i < W; i++) rd[i] = '0;
    do begin
      @(negedge clk);
      n++;
      if (tog && n == 3) addr = na;
      if (rd_valid) begin
        if (first_beat < 0) first_beat = int'(beat);
        rd[beat] = read_data;
      end
    end while (!mem_done && n < 40);
    lat = n - 1;
    if (!keep) begin
      @(posedge clk); #1;
      req = 0;
    end
  endtask

  initial begin
    logic [31:0] rd [W];
    logic [31:0] exp_wr [W];
    logic [31:0] srd [2];
    int lat, fb, n;
    bit seen;
    for (int i = 0; i < 256; i++) model_mem[i] = i;
    for (int i = 0; i < W; i++) wbuf[i] = '0;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset wr_ready", wr_ready, 0);
    check("reset mem_done", mem_done, 0);
    check("reset beat", beat, 0);
    check("reset read_data", read_data, 0);
    rst_n = 1;
    chk_en = 1;

    start(READ, 10'h014);
    finish_txn(0, 0, '0, lat, rd, fb);
    check("t1 latency", lat, 9);
    for (int i = 0; i < W; i++) check("t1 data", rd[i], 4 + i);

    exp_wr = '{32'h114514, 32'h1919, 32'h810, 32'h17};
    wbuf = exp_wr;
    start(WRITE, 10'h02C);
    finish_txn(0, 0, '0, lat, rd, fb);
    check("t2 write latency", lat, 9);
    start(READ, 10'h020);
    finish_txn(0, 0, '0, lat, rd, fb);
    for (int i = 0; i < W; i++) check("t2 readback", rd[i], exp_wr[i]);

    start(READ, 10'h02E);
    finish_txn(0, 0, '0, lat, rd, fb);
    check("t3 first beat", fb, 0);
    for (int i = 0; i < W; i++) check("t3 unaligned", rd[i], exp_wr[i]);

    start(READ, 10'h040);
    finish_txn(1, 1, 10'h0A0, lat, rd, fb);
    check("t4a latency", lat, 9);
    for (int i = 0; i < W; i++) check("t4a data", rd[i], 16 + i);
    finish_txn(0, 0, '0, lat, rd, fb);
    check("t4b latency", lat, 9);
    for (int i = 0; i < W; i++) check("t4b data", rd[i], 40 + i);

    for (int i = 0; i < W; i++) wbuf[i] = 32'hAAAA0000 + i;
    start(WRITE, 10'h0C0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wr_ready && beat == 2'd2) && n < 20);
    check("t5 reach beat2", {30'b0, wr_ready, beat[1]}, 3);
    #2 rst_n = 0;
    req = 0;
    #1;
    check("t5 rst busy", busy, 0);
    check("t5 rst wr_ready", wr_ready, 0);
    check("t5 rst mem_done", mem_done, 0);
    check("t5 rst beat", beat, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= mem_done;
    end
    check("t5 no done", seen, 0);
    start(READ, 10'h0C0);
    finish_txn(0, 0, '0, lat, rd, fb);
    check("t5 beat0", rd[0], 32'hAAAA0000);
    check("t5 beat1", rd[1], 32'hAAAA0001);
    check("t5 beat2", rd[2], 50);
    check("t5 beat3", rd[3], 51);

    srd = '{32'h0, 32'h0};
    @(posedge clk); #1;
    s_req = 1;
    s_addr = 10'h010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (s_rv) srd[s_beat] = s_rd;
    end while (!s_done && n < 20);
    check("small latency", n - 1, 4);
    check("small busy", s_busy, 1);
    check("small wr_ready", s_wr, 0);
    @(posedge clk); #1;
    s_req = 0;
    check("small beat0", srd[0], 4);
    check("small beat1", srd[1], 5);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/block_mem_responder.md
# block_mem_responder

Main-memory responder at the far end of the cache↔memory interface. It accepts block-granular read (refill) and write (write-back) requests from the cache controller and waits a fixed access latency. It then streams one 32-bit word per cycle in a burst and signals completion with a one-cycle `mem_done` pulse. It replaces the zero-time memory model with a cycle-accurate, clocked responder so that cache miss penalties are realistic.

## Interface
- `ADDR_W`, 10: byte-address width; the memory holds 2^(ADDR_W-2) words.
- `DATA_W`, 32: word width.
- `WORDS_PER_BLOCK`, 4: burst length in words; must be a power of two, ≥2.
- `LATENCY`, 4: access-delay cycles before the first beat; must be ≥1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  request valid, level; held high until `mem_done` is seen.
- `r_w_type`  in  1  0 = read block, 1 = write block; sampled with `req`.
- `addr`  in  ADDR_W  byte address; block-aligned internally, low log2(WORDS_PER_BLOCK)+2 bits ignored.
- `write_data`  in  DATA_W  write beat data for word `beat`.
- `read_data`  out  DATA_W  read beat data, valid when `rd_valid`.
- `rd_valid`  out  1  read beat valid.
- `wr_ready`  out  1  write beat consumed at this rising edge.
- `beat`  out  log2(WORDS_PER_BLOCK)  word index within block for the current beat.
- `busy`  out  1  high in any state except IDLE.
- `mem_done`  out  1  one-cycle completion pulse.

## Operation
- FSM: IDLE → WAIT → XFER → DONE → IDLE.
- IDLE: at an edge with `req=1`, latch block base = `addr[ADDR_W-1:2]` with the low log2(WORDS_PER_BLOCK) bits cleared. Also latch `r_w_type`, load the wait counter with LATENCY-1, and go to WAIT. If `req=0`, stay in IDLE.
- WAIT: decrement the counter each edge. At an edge with counter=0, clear `beat` and go to XFER.
- XFER read: `read_data` = mem[base+beat] (combinational read), `rd_valid=1`.
- XFER write: `wr_ready=1`; at each edge, mem[base+beat] ← `write_data`.
- XFER, both directions: `beat` increments each edge. At the edge with `beat`=WORDS_PER_BLOCK-1, go to DONE.
- DONE: `mem_done=1` for exactly one cycle, then IDLE unconditionally.
- `req`, `addr` and `r_w_type` are ignored outside IDLE. Changing them mid-transaction has no effect.
- The requester deasserts `req` after the edge that closes DONE. If `req` is still high in IDLE, a new transaction starts (back-to-back requests are legal).
- Memory init at time 0: word i holds value i (32-bit). Contents are not affected by reset.
- Write beats land in order. A read issued after a write to the same block returns the written data.

## Timing
- Reset values: state IDLE, counters 0, `read_data`=0 (driven 0 outside read XFER), `rd_valid`=`wr_ready`=`busy`=`mem_done`=0, `beat`=0.
- Asserting `rst_n` low mid-transaction returns to IDLE immediately and drops all outputs. A write burst in progress leaves its already-written beats committed and the remaining beats unwritten.
- Let E0 be the edge that samples `req` in IDLE:
  - WAIT occupies LATENCY cycles.
  - XFER occupies WORDS_PER_BLOCK cycles.
  - `mem_done` is high in the cycle after edge E0+LATENCY+WORDS_PER_BLOCK.
  - Defaults: request to `mem_done` = 9 cycles, 10 cycles IDLE to IDLE.
- `busy` rises the cycle after E0 and falls when DONE exits.
- The block base wraps modulo the memory size; no out-of-range accesses are possible.

## Structure
- Shared package `mem_if_pkg`:
  - R_W encoding constants: READ=0, WRITE=1, matching the CPU/cache encoding.
  - FSM state typedef (IDLE, WAIT, XFER, DONE).
  - Default WORDS_PER_BLOCK and LATENCY constants.
- Sub-module `mem_array`: word-addressed storage with synchronous write and asynchronous read, plus the time-0 init. The FSM, counters and output muxing stay in `block_mem_responder`.

## Test plan
- Reset then read of `addr`=0x014: after 4 WAIT cycles, beats 0..3 show read_data 4,5,6,7 with `rd_valid`. `mem_done` pulses in cycle 9. `busy` covers cycles 1–9.
- Write of `addr`=0x02C with beats 0x114514, 0x1919, 0x810, 0x17, then read of 0x020 → read beats return exactly those four words.
- `addr`=0x02E (unaligned byte offset) read → same block as 0x020 (words 8–11); `beat` starts at 0.
- `req` held high through DONE with a new `addr` → second transaction starts at the first IDLE edge. Toggling `addr` during WAIT of the first transaction does not change its data.
- `rst_n` pulsed low at beat 2 of a write to block 0x0C0 → outputs drop to 0 immediately and no `mem_done`. A later read shows beats 0–1 new, beats 2–3 still at init values 50, 51.
- LATENCY=1, WORDS_PER_BLOCK=2 build → request to `mem_done` = 4 cycles; read returns the correct two words.
